// File: rtl/button_conditioner_pkg.sv
// Shared defaults and per-button state record for the stopwatch button front end.
package button_conditioner_pkg;

    localparam int DEF_NUM_BTN  = 2;
    localparam int DEF_DIV_BITS = 17;
    localparam int DEF_DEPTH    = 3;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic toggle;
    } btn_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchroniser, sample history and the
// level / press / release / toggle outputs derived from it.
module debounce_cell
    import button_conditioner_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    input  logic       i_tick,
    output btn_state_t o_st
);

    logic [1:0]       r_sync;
    logic [DEPTH-1:0] r_hist;
    btn_state_t       r_st;
    logic [DEPTH-1:0] w_hist_next;

    assign w_hist_next = {r_hist[DEPTH-2:0], r_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= '0;
            r_st   <= '0;
        end else begin
            r_sync     <= {r_sync[0], i_raw};
            r_st.press <= 1'b0;
            r_st.rel   <= 1'b0;
            if (i_tick) begin
                r_hist <= w_hist_next;
                // A mixed history leaves the level alone: that is the bounce filter.
                if (&w_hist_next && !r_st.level) begin
                    r_st.level  <= 1'b1;
                    r_st.press  <= 1'b1;
                    r_st.toggle <= ~r_st.toggle;
                end else if (~|w_hist_next && r_st.level) begin
                    r_st.level <= 1'b0;
                    r_st.rel   <= 1'b1;
                end
            end
        end
    end

    assign o_st = r_st;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: shared sample-tick prescaler feeding one debounce_cell per button.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN  = DEF_NUM_BTN,
    parameter int DIV_BITS = DEF_DIV_BITS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_toggle,
    output logic               sample_tick
);

    logic [DIV_BITS-1:0] r_div;
    logic                r_tick;
    btn_state_t          w_st [NUM_BTN];

    // Tick is registered off the all-ones count, so the period is exactly 2**DIV_BITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= r_div + 1'b1;
            r_tick <= &r_div;
        end
    end

    assign sample_tick = r_tick;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        debounce_cell #(.DEPTH(DEPTH)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (btn_raw[gi]),
            .i_tick (r_tick),
            .o_st   (w_st[gi])
        );
        assign btn_level[gi]   = w_st[gi].level;
        assign btn_press[gi]   = w_st[gi].press;
        assign btn_release[gi] = w_st[gi].rel;
        assign btn_toggle[gi]  = w_st[gi].toggle;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus queues expected press/release events, a monitor
// pops and checks them whenever the DUT pulses, and checks tick timing and reset.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release, btn_toggle;
    logic       sample_tick;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic rst_d;

    typedef struct {
        logic [1:0] p, r, l, t;
        int         cyc;
    } ev_t;
    ev_t q[$];
    ev_t e;

    button_conditioner #(.NUM_BTN(2), .DIV_BITS(4), .DEPTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_d <= rst;
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_d === 1'b1) begin
            chk("reset_zero", {23'd0, sample_tick, btn_level, btn_press, btn_release, btn_toggle}, 32'd0);
        end else if (rst_d === 1'b0) begin
            chk("tick", {31'd0, sample_tick}, {31'd0, (cyc > 0 && cyc % 16 == 0)});
            if ((btn_press | btn_release) != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {24'd0, btn_press, btn_release, btn_level, btn_toggle}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ev_cyc",     cyc,                  e.cyc);
                    chk("ev_press",   {30'd0, btn_press},   {30'd0, e.p});
                    chk("ev_release", {30'd0, btn_release}, {30'd0, e.r});
                    chk("ev_level",   {30'd0, btn_level},   {30'd0, e.l});
                    chk("ev_toggle",  {30'd0, btn_toggle},  {30'd0, e.t});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw change at edge count c is seen by the cells 3 edges later; press lands
    // on the third tick that samples it, one clk after that tick is visible.
    task automatic apply(input logic [1:0] raw, input logic [1:0] p, input logic [1:0] r,
                         input logic [1:0] l, input logic [1:0] t);
        ev_t x;
        int  k0;
        btn_raw = raw;
        k0    = (cyc + 2 + 15) / 16;
        x.p   = p; x.r = r; x.l = l; x.t = t;
        x.cyc = 16 * (k0 + 2) + 1;
        q.push_back(x);
        for (int i = 0; i < 200 && cyc <= x.cyc + 1; i++) step(1);
    endtask

    task automatic align(input int ph);
        for (int i = 0; i < 32 && (cyc % 16) != ph; i++) step(1);
    endtask

    initial begin
        // 1: reset with buttons held, released idle
        step(5);
        rst = 1'b0;
        btn_raw = 2'b00;
        step(60);
        chk("idle_level",  {30'd0, btn_level},  32'd0);
        chk("idle_toggle", {30'd0, btn_toggle}, 32'd0);

        // 2: clean press / release of btn0
        apply(2'b01, 2'b01, 2'b00, 2'b01, 2'b01);
        apply(2'b00, 2'b00, 2'b01, 2'b00, 2'b01);

        // 3: bounce then settle high -> single press
        align(4);
        for (int j = 0; j < 12; j++) begin
            btn_raw = {1'b0, (j % 2 == 0)};
            step(5);
        end
        apply(2'b01, 2'b01, 2'b00, 2'b01, 2'b00);

        // 4: short glitch on btn1
        btn_raw = 2'b11;
        step(20);
        btn_raw = 2'b01;
        step(64);
        chk("glitch_level", {30'd0, btn_level}, 32'd1);

        // 5: simultaneous presses, then second press of btn0 only
        apply(2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        apply(2'b11, 2'b11, 2'b00, 2'b11, 2'b11);
        apply(2'b10, 2'b00, 2'b01, 2'b10, 2'b11);
        apply(2'b11, 2'b01, 2'b00, 2'b11, 2'b10);

        // 6: 1-clk reset with buttons held
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_level",  {30'd0, btn_level},  32'd0);
        chk("rst_toggle", {30'd0, btn_toggle}, 32'd0);
        apply(2'b11, 2'b11, 2'b00, 2'b11, 2'b11);

        step(5);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
